// File: rtl/dnn_wr_scheduler.sv
// Write-path scheduler: arbitrates round-robin between PUs holding output
// data and issues one burst write request at a time to the memory controller.
module dnn_wr_scheduler #(
   parameter int NUM_PU        = 2,
   parameter int ADDR_W        = 32,
   parameter int TX_SIZE_WIDTH = 10,
   parameter int AXI_DATA_W    = 64,
   parameter int PU_ID_W       = $clog2(NUM_PU) + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [ADDR_W-1:0]        cfg_base_addr,
   input  logic [ADDR_W-1:0]        cfg_pu_stride,
   input  logic [TX_SIZE_WIDTH-1:0] cfg_tx_size,
   input  logic [15:0]              cfg_num_tx,
   input  logic [NUM_PU-1:0]        pu_wr_pending,
   output logic                     wr_req,
   input  logic                     wr_ready,
   output logic [PU_ID_W-1:0]       wr_pu_id,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [TX_SIZE_WIDTH-1:0] wr_req_size,
   input  logic                     wr_done,
   output logic                     busy,
   output logic                     done
);

   localparam int BPB = AXI_DATA_W / 8;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_ARB       = 3'd1;
   localparam logic [2:0] ST_REQ       = 3'd2;
   localparam logic [2:0] ST_WAIT_DONE = 3'd3;
   localparam logic [2:0] ST_FINISH    = 3'd4;

   localparam logic [PU_ID_W-1:0] LAST_PU = PU_ID_W'(NUM_PU - 1);

   logic [2:0]               state_r;
   logic [2:0]               state_nxt_s;
   logic [TX_SIZE_WIDTH-1:0] tx_size_r;
   logic [PU_ID_W-1:0]       last_grant_r;
   logic [PU_ID_W-1:0]       cur_r;
   logic [15:0]              remaining_r [NUM_PU];
   logic [ADDR_W-1:0]        ptr_r       [NUM_PU];
   logic [ADDR_W-1:0]        start_ptr_s [NUM_PU];

   logic [NUM_PU-1:0]        eligible_s;
   logic                     all_zero_s;
   logic                     found_s;
   logic [PU_ID_W-1:0]       grant_s;
   logic [ADDR_W-1:0]        grant_addr_s;
   logic [ADDR_W-1:0]        burst_bytes_s;
   logic                     accept_s;
   logic                     pass_start_s;

   logic                     wr_req_r;
   logic [PU_ID_W-1:0]       wr_pu_id_r;
   logic [ADDR_W-1:0]        wr_addr_r;
   logic [TX_SIZE_WIDTH-1:0] wr_req_size_r;
   logic                     busy_r;
   logic                     done_r;

   assign wr_req      = wr_req_r;
   assign wr_pu_id    = wr_pu_id_r;
   assign wr_addr     = wr_addr_r;
   assign wr_req_size = wr_req_size_r;
   assign busy        = busy_r;
   assign done        = done_r;

   assign pass_start_s  = (state_r == ST_IDLE) && start;
   assign accept_s      = (state_r == ST_REQ) && wr_req_r && wr_ready;
   assign burst_bytes_s = ADDR_W'(tx_size_r) * ADDR_W'(BPB);

   // Per-PU eligibility and the all-bursts-issued condition.
   always_comb begin
      all_zero_s = 1'b1;
      eligible_s = {NUM_PU{1'b0}};
      for (int i = 0; i < NUM_PU; i++) begin
         eligible_s[i] = pu_wr_pending[i] && (remaining_r[i] != 16'd0);
         if (remaining_r[i] != 16'd0) begin
            all_zero_s = 1'b0;
         end else begin
            all_zero_s = all_zero_s;
         end
      end
   end

   // Region start addresses, accumulated so the stride wraps modulo 2^ADDR_W.
   always_comb begin
      logic [ADDR_W-1:0] acc_s;
      acc_s = cfg_base_addr;
      for (int i = 0; i < NUM_PU; i++) begin
         start_ptr_s[i] = acc_s;
         acc_s          = acc_s + cfg_pu_stride;
      end
   end

   // Round-robin search beginning one past the last granted PU.
   always_comb begin
      int idx;
      idx          = 0;
      found_s      = 1'b0;
      grant_s      = {PU_ID_W{1'b0}};
      grant_addr_s = {ADDR_W{1'b0}};
      for (int k = 1; k <= NUM_PU; k++) begin
         idx = int'(last_grant_r) + k;
         if (idx >= NUM_PU) begin
            idx = idx - NUM_PU;
         end else begin
            idx = idx;
         end
         for (int j = 0; j < NUM_PU; j++) begin
            if (!found_s && (j == idx) && eligible_s[j]) begin
               found_s      = 1'b1;
               grant_s      = PU_ID_W'(j);
               grant_addr_s = ptr_r[j];
            end else begin
               found_s      = found_s;
            end
         end
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_nxt_s = ST_ARB;
            else       state_nxt_s = ST_IDLE;
         end
         ST_ARB: begin
            if (all_zero_s)   state_nxt_s = ST_FINISH;
            else if (found_s) state_nxt_s = ST_REQ;
            else              state_nxt_s = ST_ARB;
         end
         ST_REQ: begin
            if (accept_s) state_nxt_s = ST_WAIT_DONE;
            else          state_nxt_s = ST_REQ;
         end
         ST_WAIT_DONE: begin
            if (wr_done) state_nxt_s = ST_ARB;
            else         state_nxt_s = ST_WAIT_DONE;
         end
         ST_FINISH: state_nxt_s = ST_IDLE;
         default:   state_nxt_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Per-PU burst counters and address pointers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PU; i++) begin
            remaining_r[i] <= 16'd0;
            ptr_r[i]       <= {ADDR_W{1'b0}};
         end
      end else if (pass_start_s) begin
         for (int i = 0; i < NUM_PU; i++) begin
            remaining_r[i] <= cfg_num_tx;
            ptr_r[i]       <= start_ptr_s[i];
         end
      end else if (accept_s) begin
         for (int i = 0; i < NUM_PU; i++) begin
            if (PU_ID_W'(i) == cur_r) begin
               remaining_r[i] <= remaining_r[i] - 16'd1;
               ptr_r[i]       <= ptr_r[i] + burst_bytes_s;
            end
         end
      end
   end

   // Latched burst size, arbitration history and the PU currently served.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_size_r    <= {TX_SIZE_WIDTH{1'b0}};
         last_grant_r <= LAST_PU;
         cur_r        <= {PU_ID_W{1'b0}};
      end else begin
         if (pass_start_s) begin
            tx_size_r <= cfg_tx_size;
         end
         if ((state_r == ST_ARB) && !all_zero_s && found_s) begin
            last_grant_r <= grant_s;
            cur_r        <= grant_s;
         end
      end
   end

   // Registered request fields and pass status.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_req_r      <= 1'b0;
         wr_pu_id_r    <= {PU_ID_W{1'b0}};
         wr_addr_r     <= {ADDR_W{1'b0}};
         wr_req_size_r <= {TX_SIZE_WIDTH{1'b0}};
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               busy_r <= start;
            end
            ST_ARB: begin
               if (all_zero_s) begin
                  done_r <= 1'b1;
               end else if (found_s) begin
                  wr_req_r      <= 1'b1;
                  wr_pu_id_r    <= grant_s;
                  wr_addr_r     <= grant_addr_s;
                  wr_req_size_r <= tx_size_r;
               end
            end
            ST_REQ: begin
               if (accept_s) begin
                  wr_req_r <= 1'b0;
               end
            end
            ST_WAIT_DONE: begin
               wr_req_r <= 1'b0;
            end
            ST_FINISH: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
            end
            default: begin
               wr_req_r <= 1'b0;
               done_r   <= 1'b0;
               busy_r   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dnn_wr_scheduler.sv
// Directed bench for dnn_wr_scheduler: table of complete passes plus
// hand-written sequences for stall, starvation, reset and wrap corner cases.
module tb_dnn_wr_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] cfg_base_addr = 32'd0;
   logic [31:0] cfg_pu_stride = 32'd0;
   logic [9:0]  cfg_tx_size = 10'd0;
   logic [15:0] cfg_num_tx = 16'd0;
   logic [1:0]  pu_wr_pending = 2'b00;
   logic        wr_req;
   logic        wr_ready = 1'b0;
   logic [1:0]  wr_pu_id;
   logic [31:0] wr_addr;
   logic [9:0]  wr_req_size;
   logic        wr_done = 1'b0;
   logic        busy;
   logic        done;

   dnn_wr_scheduler dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_base_addr(cfg_base_addr), .cfg_pu_stride(cfg_pu_stride),
      .cfg_tx_size(cfg_tx_size), .cfg_num_tx(cfg_num_tx),
      .pu_wr_pending(pu_wr_pending), .wr_req(wr_req), .wr_ready(wr_ready),
      .wr_pu_id(wr_pu_id), .wr_addr(wr_addr), .wr_req_size(wr_req_size),
      .wr_done(wr_done), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]       base;
      logic [31:0]       stride;
      logic [9:0]        tx;
      logic [15:0]       num;
      int                n;
      logic [0:3][1:0]   id;
      logic [0:3][31:0]  addr;
   } vec_t;

   vec_t vecs [4];

   int n_checks = 0;
   int n_pass = 0;
   int cyc, done_cyc, first_req_cyc, dcnt;
   bit saw_done;
   logic [1:0]  got_id   [$];
   logic [31:0] got_addr [$];
   logic [9:0]  got_size [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [63:0] q_id(input int k);
      if (k < got_id.size()) return 64'(got_id[k]);
      else return {64{1'bx}};
   endfunction

   function automatic logic [63:0] q_addr(input int k);
      if (k < got_addr.size()) return 64'(got_addr[k]);
      else return {64{1'bx}};
   endfunction

   function automatic logic [63:0] q_size(input int k);
      if (k < got_size.size()) return 64'(got_size[k]);
      else return {64{1'bx}};
   endfunction

   // Called at a negedge: pulses start, then scrambles cfg to show it was latched.
   task automatic begin_pass(input logic [31:0] base, input logic [31:0] stride,
                             input logic [9:0] tx, input logic [15:0] num);
      cfg_base_addr = base;
      cfg_pu_stride = stride;
      cfg_tx_size   = tx;
      cfg_num_tx    = num;
      start         = 1'b1;
      got_id.delete(); got_addr.delete(); got_size.delete();
      saw_done = 1'b0; first_req_cyc = -1; dcnt = 0; done_cyc = -1;
      @(negedge clk);
      start = 1'b0;
      cfg_base_addr = ~base;
      cfg_pu_stride = stride + 32'h40;
      cfg_tx_size   = tx + 10'd3;
      cfg_num_tx    = num + 16'd5;
      cyc = 1;
   endtask

   // Records accepted requests and answers each with wr_done three cycles later.
   task automatic service(input int budget);
      while (cyc < budget && !saw_done) begin
         wr_done = 1'b0;
         if (done) begin
            saw_done = 1'b1;
            done_cyc = cyc;
         end else if (wr_req) begin
            if (wr_ready) begin
               got_id.push_back(wr_pu_id);
               got_addr.push_back(wr_addr);
               got_size.push_back(wr_req_size);
               if (first_req_cyc < 0) first_req_cyc = cyc;
               dcnt = 3;
            end
         end else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) wr_done = 1'b1;
         end
         if (!saw_done) begin
            @(negedge clk);
            cyc++;
         end
      end
      wr_done = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32'h0000_1000, 32'h100, 10'd4,     16'd2, 4, {2'd0, 2'd1, 2'd0, 2'd1},
                  {32'h0000_1000, 32'h0000_1100, 32'h0000_1020, 32'h0000_1120}};
      vecs[1] = '{32'h0000_0000, 32'h040, 10'd1,     16'd1, 2, {2'd0, 2'd1, 2'd0, 2'd0},
                  {32'h0000_0000, 32'h0000_0040, 32'h0, 32'h0}};
      vecs[2] = '{32'h0000_2000, 32'h008, 10'h3FF,   16'd2, 4, {2'd0, 2'd1, 2'd0, 2'd1},
                  {32'h0000_2000, 32'h0000_2008, 32'h0000_3FF8, 32'h0000_4000}};
      vecs[3] = '{32'hFFFF_FF00, 32'h200, 10'd2,     16'd1, 2, {2'd0, 2'd1, 2'd0, 2'd0},
                  {32'hFFFF_FF00, 32'h0000_0100, 32'h0, 32'h0}};

      repeat (3) @(negedge clk);
      check("rst_wr_req", wr_req, 0);
      check("rst_id", wr_pu_id, 0);
      check("rst_addr", wr_addr, 0);
      check("rst_size", wr_req_size, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table of full passes with both PUs pending and an always-ready controller.
      pu_wr_pending = 2'b11;
      wr_ready = 1'b1;
      for (int v = 0; v < 4; v++) begin
         begin_pass(vecs[v].base, vecs[v].stride, vecs[v].tx, vecs[v].num);
         service(400);
         check($sformatf("v%0d_done_seen", v), saw_done, 1);
         check($sformatf("v%0d_nreq", v), got_id.size(), vecs[v].n);
         check($sformatf("v%0d_latency", v), first_req_cyc, 2);
         for (int k = 0; k < vecs[v].n; k++) begin
            check($sformatf("v%0d_id%0d", v, k), q_id(k), 64'(vecs[v].id[k]));
            check($sformatf("v%0d_addr%0d", v, k), q_addr(k), 64'(vecs[v].addr[k]));
            check($sformatf("v%0d_size%0d", v, k), q_size(k), 64'(vecs[v].tx));
         end
         @(negedge clk);
         check($sformatf("v%0d_done_pulse", v), done, 0);
         check($sformatf("v%0d_idle_busy", v), busy, 0);
      end

      // Empty pass.
      begin_pass(32'h1000, 32'h100, 10'd4, 16'd0);
      service(20);
      check("empty_done_seen", saw_done, 1);
      check("empty_done_cyc", done_cyc, 2);
      check("empty_nreq", got_id.size(), 0);
      @(negedge clk);
      check("empty_busy", busy, 0);

      // Backpressure: wr_ready low for five cycles while requesting.
      wr_ready = 1'b0;
      begin_pass(32'h3000, 32'h400, 10'd5, 16'd1);
      for (int w = 0; w < 10 && !wr_req; w++) @(negedge clk);
      for (int s = 0; s < 5; s++) begin
         check($sformatf("stall%0d_req", s), wr_req, 1);
         check($sformatf("stall%0d_id", s), wr_pu_id, 0);
         check($sformatf("stall%0d_addr", s), wr_addr, 32'h3000);
         check($sformatf("stall%0d_size", s), wr_req_size, 5);
         @(negedge clk);
      end
      wr_ready = 1'b1;
      service(200);
      check("stall_nreq", got_id.size(), 2);
      check("stall_id0", q_id(0), 0);
      check("stall_addr0", q_addr(0), 32'h3000);
      check("stall_id1", q_id(1), 1);
      check("stall_addr1", q_addr(1), 32'h3400);
      check("stall_done", saw_done, 1);

      // Only PU1 pending: PU1 served, then arbitration waits for PU0.
      @(negedge clk);
      pu_wr_pending = 2'b10;
      begin_pass(32'h500, 32'h80, 10'd2, 16'd1);
      service(25);
      check("starve_nreq", got_id.size(), 1);
      check("starve_id0", q_id(0), 1);
      check("starve_addr0", q_addr(0), 32'h580);
      check("starve_no_done", saw_done, 0);
      check("starve_busy", busy, 1);
      check("starve_no_req", wr_req, 0);
      pu_wr_pending = 2'b11;
      service(80);
      check("starve_nreq2", got_id.size(), 2);
      check("starve_id1", q_id(1), 0);
      check("starve_addr1", q_addr(1), 32'h500);
      check("starve_done", saw_done, 1);

      // Reset while waiting for wr_done.
      @(negedge clk);
      begin_pass(32'h1000, 32'h100, 10'd4, 16'd2);
      for (int w = 0; w < 10 && !wr_req; w++) @(negedge clk);
      @(negedge clk);
      check("wd_busy", busy, 1);
      check("wd_req_low", wr_req, 0);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_req", wr_req, 0);
      check("mid_rst_id", wr_pu_id, 0);
      check("mid_rst_addr", wr_addr, 0);
      check("mid_rst_size", wr_req_size, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      begin_pass(32'h7000, 32'h100, 10'd4, 16'd1);
      service(200);
      check("post_rst_id0", q_id(0), 0);
      check("post_rst_addr0", q_addr(0), 32'h7000);
      check("post_rst_id1", q_id(1), 1);
      check("post_rst_addr1", q_addr(1), 32'h7100);
      check("post_rst_done", saw_done, 1);

      // Address wrap on PU0 with stray wr_done pulses in IDLE and ARB.
      @(negedge clk);
      pu_wr_pending = 2'b00;
      wr_done = 1'b1;
      @(negedge clk);
      wr_done = 1'b0;
      check("stray_idle_busy", busy, 0);
      check("stray_idle_req", wr_req, 0);
      begin_pass(32'hFFFF_FFF0, 32'h10, 10'd4, 16'd2);
      wr_done = 1'b1;
      @(negedge clk);
      wr_done = 1'b0;
      check("stray_arb_busy", busy, 1);
      check("stray_arb_req", wr_req, 0);
      pu_wr_pending = 2'b01;
      service(60);
      check("wrap_nreq", got_id.size(), 2);
      check("wrap_id0", q_id(0), 0);
      check("wrap_addr0", q_addr(0), 32'hFFFF_FFF0);
      check("wrap_id1", q_id(1), 0);
      check("wrap_addr1", q_addr(1), 32'h0000_0010);
      check("wrap_no_done", saw_done, 0);
      pu_wr_pending = 2'b11;
      service(200);
      check("wrap_nreq2", got_id.size(), 4);
      check("wrap_id2", q_id(2), 1);
      check("wrap_addr2", q_addr(2), 32'h0000_0000);
      check("wrap_addr3", q_addr(3), 32'h0000_0020);
      check("wrap_done", saw_done, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
